pipe_if_stage: RTL and testbench
================================

// Module: pipe_if_stage
// PURPOSE
// - Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode stage.
// - Owns the PC and selects the next PC from the decode stage's pcsource/bpc/da/jpc.
// - Fetches over a req/ack instruction-memory handshake with variable latency.
// - Drives dpc4/inst into decode; honours the decode load-use stall (wpcir).
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC value after reset
// - NOP_INST  32'h0000_0000  bubble word loaded into IF/ID when no instruction is delivered
// PORTS
// - clock       in   1   single clock, all state on posedge
// - reset       in   1   synchronous, active-high reset
// - pcsource    in   2   from decode: 00 pc+4, 01 bpc, 10 da (jr), 11 jpc
// - bpc         in   32  branch target from decode
// - da          in   32  forwarded rs value from decode (jr target)
// - jpc         in   32  jump target from decode
// - wpcir       in   1   1 = decode accepts a new IF/ID word; 0 = stall, hold IF/ID
// - imem_addr   out  32  fetch address (= pc)
// - imem_req    out  1   fetch request
// - imem_rdata  in   32  instruction word, valid when imem_ack
// - imem_ack    in   1   fetch complete this cycle
// - dpc4        out  32  IF/ID: address of fetched instruction + 4
// - inst        out  32  IF/ID: fetched instruction
// BEHAVIOUR
// - Reset: pc=RESET_PC, dpc4=0, inst=NOP_INST, imem_req=0, state=IDLE, redir_v=0, hold buffer cleared.
// - Reset overrides everything; reset mid-fetch drops the outstanding request; a late ack is ignored.
// - IDLE: imem_req=0 for one cycle, then -> WAIT.
// - WAIT: imem_req=1, imem_addr=pc stable until ack.
//   - ack & wpcir: IF/ID <= {pc+4, imem_rdata}; pc <= npc; stay in WAIT and issue next request the next cycle.
//   - ack & ~wpcir: buffer <= imem_rdata; IF/ID held; -> HOLD.
//   - ~ack & wpcir: IF/ID <= {dpc4 unchanged, NOP_INST} (bubble); pc held.
//   - ~ack & ~wpcir: everything held.
// - HOLD: imem_req=0.
//   - wpcir: IF/ID <= {pc+4, buffer}; pc <= npc; -> WAIT.
//   - ~wpcir: held.
// - Transfer = cycle in which IF/ID loads a real instruction.
// - Redirect capture:
//   - Condition: wpcir=1 & pcsource!=00 & no transfer this cycle.
//   - Action: redir_pc <= sel(pcsource); redir_v <= 1.
//   - sel(pcsource): 01 -> bpc, 10 -> da, 11 -> jpc.
// - npc at transfer:
//   - pcsource!=00 & wpcir -> sel(pcsource);
//   - else redir_v -> redir_pc;
//   - else pc+4.
//   - redir_v cleared on transfer.
// - Simultaneous: a new redirect in the same cycle as a pending redir_v overwrites it.
// - Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC+4 = 0. No alignment check; pc[1:0] passed through.
// - Latency: zero-wait memory (ack in the cycle after req rises) sustains 1 instruction/cycle after the first.
// - First fetched instruction reaches IF/ID 2 cycles after reset deasserts.
// CONFIGURATION
// - IF_FLUSH_EN defined:
//   - A transfer whose npc comes from a redirect loads NOP_INST into inst instead of the fetched word, squashing the delay slot.
//   - dpc4 still updates.
// - IF_FLUSH_EN undefined: MIPS delayed branch; the delay-slot instruction passes to decode unchanged.
// TESTING
// - Reset then zero-wait mem: addrs 0,4,8 requested; inst follows imem_rdata; dpc4 = 4,8,12.
// - ack with wpcir=0 for 2 cycles:
//   - state HOLD, imem_req=0, IF/ID unchanged;
//   - on wpcir=1, inst = buffered word, next req addr = pc+4.
// - Slow mem (ack 3 cycles after req), wpcir=1: inst = NOP_INST for 2 cycles, imem_addr stable throughout.
// - pcsource=01, bpc=32'h100 while delay-slot fetch at 32'h14 waits 2 cycles:
//   - next req addr = 32'h100;
//   - inst at 32'h14 delivered, or NOP if IF_FLUSH_EN.
// - pcsource=10, da=32'h40 with zero-wait mem: next req addr = 32'h40.
// - pcsource=11, jpc=32'h2000 with zero-wait mem: next req addr = 32'h2000.
// - reset=1 while WAIT at pc=32'h8, ack arrives same cycle:
//   - pc=RESET_PC, inst=NOP_INST, imem_req=0;
//   - next req addr = 0.

Source files
------------

// File: rtl/pipe_if_stage_if.sv
// Instruction-memory fetch handshake between pipe_if_stage (master) and the memory (slave).
// req stays high with a stable addr until the cycle ack is high; rdata is only meaningful when ack=1.
interface pipe_if_stage_if;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage with IF/ID register, variable-latency req/ack fetch and redirect capture.
// Define IF_FLUSH_EN to squash the delay-slot instruction on a redirected transfer.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            pcsource,
  input  logic [31:0]           bpc,
  input  logic [31:0]           da,
  input  logic [31:0]           jpc,
  input  logic                  wpcir,
  pipe_if_stage_if.master       imem,
  output logic [31:0]           dpc4,
  output logic [31:0]           inst,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_v_q, redir_v_d;

  logic [31:0] pc_plus4;
  logic [31:0] sel_pc;
  logic [31:0] npc;
  logic [31:0] fetched;
  logic        redirect_now;
  logic        transfer;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_now = wpcir && (pcsource != 2'b00);

  always_comb begin
    sel_pc = jpc;
    case (pcsource)
      2'b01:   sel_pc = bpc;
      2'b10:   sel_pc = da;
      default: sel_pc = jpc;
    endcase
  end

  // A redirect seen on the transfer cycle itself wins over an older captured one.
  always_comb begin
    npc = pc_plus4;
    if (redirect_now) begin
      npc = sel_pc;
    end else if (redir_v_q) begin
      npc = redir_pc_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    dpc4_d     = dpc4_q;
    inst_d     = inst_q;
    buf_d      = buf_q;
    redir_pc_d = redir_pc_q;
    redir_v_d  = redir_v_q;
    transfer   = 1'b0;
    fetched    = buf_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_ack) begin
          if (wpcir) begin
            transfer = 1'b1;
            fetched  = imem.imem_rdata;
          end else begin
            buf_d   = imem.imem_rdata;
            state_d = S_HOLD;
          end
        end else if (wpcir) begin
          inst_d = NOP_INST;
        end
      end
      S_HOLD: begin
        if (wpcir) begin
          transfer = 1'b1;
          fetched  = buf_q;
          state_d  = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (transfer) begin
      pc_d      = npc;
      dpc4_d    = pc_plus4;
`ifdef IF_FLUSH_EN
      inst_d    = (redirect_now || redir_v_q) ? NOP_INST : fetched;
`else
      inst_d    = fetched;
`endif
      redir_v_d = 1'b0;
    end else if (redirect_now) begin
      redir_pc_d = sel_pc;
      redir_v_d  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      dpc4_q     <= 32'd0;
      inst_q     <= NOP_INST;
      buf_q      <= 32'd0;
      redir_pc_q <= 32'd0;
      redir_v_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      dpc4_q     <= dpc4_d;
      inst_q     <= inst_d;
      buf_q      <= buf_d;
      redir_pc_q <= redir_pc_d;
      redir_v_q  <= redir_v_d;
    end
  end

  assign imem.imem_addr = pc_q;
  assign imem.imem_req  = (state_q == S_WAIT);
  assign dpc4           = dpc4_q;
  assign inst           = inst_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Bench for pipe_if_stage: directed fetch scenarios with literal expectations, then random
// stimulus against a behavioural reference model checked every cycle.
module tb_pipe_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IF_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc;
  logic        wpcir;
  logic [31:0] dpc4, inst;
  logic [1:0]  dbg_state;

  pipe_if_stage_if imem();

  pipe_if_stage dut (
    .clock       (clock),
    .reset       (reset),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .da          (da),
    .jpc         (jpc),
    .wpcir       (wpcir),
    .imem        (imem),
    .dpc4        (dpc4),
    .inst        (inst),
    .dbg_state_o (dbg_state)
  );

  // Clock and counters
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: decides ack just after each rising edge so it acts combinationally on req.
  int lat  = 0;
  bit spur = 1'b0;
  int cnt  = 0;

  initial begin
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'd0;
  end

  always @(posedge clock) begin
    #1;
    if (imem.imem_req) begin
      if (cnt >= lat) begin
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = mem_word(imem.imem_addr);
        cnt = 0;
      end else begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = $urandom;
        cnt++;
      end
    end else begin
      imem.imem_ack   = spur && ($urandom_range(0, 1) == 1);
      imem.imem_rdata = $urandom;
      cnt = 0;
    end
  end

  // Reference model: PC, IF/ID contents, whether the one-cycle startup gap is over,
  // a captured-but-unconsumed fetched word, and a pending-redirect queue (at most one entry).
  logic [31:0] m_pc, m_dpc4, m_inst, m_buf;
  bit          m_started, m_have_word;
  logic [31:0] m_redir[$];
  logic [31:0] m_word, m_next;
  bit          m_got, m_redirected;

  function automatic logic [31:0] target(input logic [1:0] ps);
    return (ps == 2'b01) ? bpc : (ps == 2'b10) ? da : jpc;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_pc = 32'd0; m_dpc4 = 32'd0; m_inst = NOP; m_buf = 32'd0;
      m_started = 1'b0; m_have_word = 1'b0;
      m_redir.delete();
    end else begin
      m_got  = m_started && (m_have_word || imem.imem_ack);
      m_word = m_have_word ? m_buf : imem.imem_rdata;
      if (m_got && wpcir) begin
        m_redirected = 1'b1;
        if (pcsource != 2'b00) m_next = target(pcsource);
        else if (m_redir.size() > 0) m_next = m_redir[0];
        else begin
          m_next = m_pc + 32'd4;
          m_redirected = 1'b0;
        end
        m_dpc4 = m_pc + 32'd4;
        m_inst = (FLUSH && m_redirected) ? NOP : m_word;
        m_pc = m_next;
        m_redir.delete();
        m_have_word = 1'b0;
      end else begin
        if (wpcir && pcsource != 2'b00) begin
          m_redir.delete();
          m_redir.push_back(target(pcsource));
        end
        if (m_got && !m_have_word) begin
          m_buf = imem.imem_rdata;
          m_have_word = 1'b1;
        end else if (m_started && !m_got && wpcir) begin
          m_inst = NOP;
        end
      end
      m_started = 1'b1;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clock) begin
    check("cmp_req",   {31'd0, imem.imem_req}, {31'd0, m_started && !m_have_word});
    check("cmp_addr",  imem.imem_addr, m_pc);
    check("cmp_dpc4",  dpc4, m_dpc4);
    check("cmp_inst",  inst, m_inst);
    check("cmp_state", {30'd0, dbg_state},
          !m_started ? 32'd0 : (m_have_word ? 32'd2 : 32'd1));
  end

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      2:       return 32'($urandom_range(0, 255));
      default: return 32'($urandom_range(0, 255)) << 2;
    endcase
  endfunction

  // Directed scenarios then random stimulus
  initial begin
    reset = 1'b1; wpcir = 1'b1; pcsource = 2'b00;
    bpc = 32'd0; da = 32'd0; jpc = 32'd0;

    repeat (3) tick();
    check("rst_req",   {31'd0, imem.imem_req}, 32'd0);
    check("rst_inst",  inst, NOP);
    check("rst_dpc4",  dpc4, 32'd0);
    check("rst_addr",  imem.imem_addr, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    tick();
    check("first_req",  {31'd0, imem.imem_req}, 32'd1);
    check("first_addr", imem.imem_addr, 32'h0);
    tick();
    check("zw_addr4", imem.imem_addr, 32'h4);
    check("zw_dpc4",  dpc4, 32'h4);
    check("zw_inst0", inst, 32'h1357_9BDF);
    tick();
    check("zw_addr8", imem.imem_addr, 32'h8);
    check("zw_dpc8",  dpc4, 32'h8);
    check("zw_inst4", inst, 32'h1357_9BDB);
    tick();
    check("zw_dpc12", dpc4, 32'hC);
    check("zw_inst8", inst, 32'h1357_9BD7);
    wpcir = 1'b0;

    tick();
    check("hold_state1", {30'd0, dbg_state}, 32'd2);
    check("hold_req1",   {31'd0, imem.imem_req}, 32'd0);
    check("hold_inst1",  inst, 32'h1357_9BD7);
    tick();
    check("hold_state2", {30'd0, dbg_state}, 32'd2);
    check("hold_dpc4",   dpc4, 32'hC);
    wpcir = 1'b1;
    tick();
    check("hold_release_inst", inst, 32'h1357_9BD3);
    check("hold_release_addr", imem.imem_addr, 32'h10);
    lat = 2;
    tick();
    check("slow_pre_inst", inst, 32'h1357_9BCF);
    tick();
    check("slow_bubble1", inst, NOP);
    check("slow_addr1",   imem.imem_addr, 32'h14);
    check("slow_dpc4",    dpc4, 32'h14);
    tick();
    check("slow_bubble2", inst, NOP);
    check("slow_addr2",   imem.imem_addr, 32'h14);
    lat = 0;
    tick();
    check("slow_done_inst", inst, 32'h1357_9BCB);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    repeat (3) tick();
    check("mid_addr8", imem.imem_addr, 32'h8);
    reset = 1'b1;
    tick();
    check("mid_rst_addr", imem.imem_addr, 32'h0);
    check("mid_rst_inst", inst, NOP);
    check("mid_rst_req",  {31'd0, imem.imem_req}, 32'd0);
    reset = 1'b0;
    tick();
    check("mid_rst_next_addr", imem.imem_addr, 32'h0);

    repeat (4) tick();
    lat = 2;
    tick();
    check("br_slot_addr", imem.imem_addr, 32'h14);
    pcsource = 2'b01; bpc = 32'h100;
    tick();
    pcsource = 2'b00;
    tick();
    check("br_wait_addr", imem.imem_addr, 32'h14);
    lat = 0;
    tick();
    check("br_target_addr", imem.imem_addr, 32'h100);
    check("br_slot_dpc4",   dpc4, 32'h18);
    check("br_slot_inst",   inst, FLUSH ? NOP : 32'h1357_9BCB);
    pcsource = 2'b10; da = 32'h40;
    tick();
    check("jr_addr", imem.imem_addr, 32'h40);
    check("jr_inst", inst, FLUSH ? NOP : 32'h1357_9ADF);
    pcsource = 2'b11; jpc = 32'h2000;
    tick();
    check("j_addr", imem.imem_addr, 32'h2000);
    check("j_dpc4", dpc4, 32'h44);
    jpc = 32'hFFFF_FFFC;
    tick();
    check("wrap_hi_addr", imem.imem_addr, 32'hFFFF_FFFC);
    pcsource = 2'b00;
    tick();
    check("wrap_addr", imem.imem_addr, 32'h0);
    check("wrap_dpc4", dpc4, 32'h0);
    check("wrap_inst", inst, 32'hECA8_6423);

    spur = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      tick();
      reset    = ($urandom_range(0, 149) == 0);
      wpcir    = ($urandom_range(0, 3) != 0);
      pcsource = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bpc      = rand_target();
      da       = rand_target();
      jpc      = rand_target();
      if ($urandom_range(0, 15) == 0) lat = $urandom_range(0, 3);
    end
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
